// File: rtl/operand_fetch.sv
// Issue-side operand fetch: drives register file reads, tracks pending writes in a
// busy scoreboard, stalls on RAW/WAW hazards and holds operands in a one-entry output register.
module operand_fetch #(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // decoded instruction
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_wr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  // register file read ports
  output logic             rf_re1,
  output logic             rf_re2,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  // writeback and register file write port
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  // control
  input  logic             flush,
  // execute-side output register
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [4:0]       out_rd,
  output logic             out_wr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm
);

  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RW-1:0]   rd;
    logic            wr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } out_pl_t;

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  out_pl_t         out_pl_q, out_pl_d;

  logic [NREG-1:0] busy_eff;
  logic            hazard;
  logic            accept;

  // Scoreboard view with this cycle's retiring writeback already cleared
  always_comb begin
    busy_eff = busy_q;
    if (wb_valid) begin
      busy_eff[wb_addr] = 1'b0;
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (in_use_rs1 && (in_rs1 != RW'(0)) && busy_eff[in_rs1]) hazard = 1'b1;
    if (in_use_rs2 && (in_rs2 != RW'(0)) && busy_eff[in_rs2]) hazard = 1'b1;
    if (in_wr && (in_rd != RW'(0)) && busy_eff[in_rd])        hazard = 1'b1;
  end

  assign in_ready = rst_n && !hazard && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Reads go out every cycle, stalled or not
  assign rf_re1    = in_valid && in_use_rs1;
  assign rf_re2    = in_valid && in_use_rs2;
  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign rf_we    = wb_valid;
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

  // Scoreboard update: writeback clear first so a same-register accept set wins
  always_comb begin
    busy_d = busy_eff;
    if (accept && in_wr && (in_rd != RW'(0))) begin
      busy_d[in_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pl_d    = out_pl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_pl_d.op1 = in_use_rs1 ? rf_rdata1 : XLEN'(0);
      out_pl_d.op2 = in_use_rs2 ? rf_rdata2 : XLEN'(0);
      out_pl_d.rd  = in_rd;
      out_pl_d.wr  = in_wr;
      out_pl_d.pc  = in_pc;
      out_pl_d.imm = in_imm;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_pl_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_pl_q    <= out_pl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_pl_q.op1;
  assign out_op2   = out_pl_q.op2;
  assign out_rd    = out_pl_q.rd;
  assign out_wr    = out_pl_q.wr;
  assign out_pc    = out_pl_q.pc;
  assign out_imm   = out_pl_q.imm;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register file model that bypasses
// same-cycle writes into the read data.
module tb_operand_fetch;

  localparam int unsigned XLEN = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic             in_use_rs1, in_use_rs2, in_wr;
  logic [XLEN-1:0]  in_pc, in_imm;
  logic             rf_re1, rf_re2;
  logic [4:0]       rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]  rf_rdata1, rf_rdata2;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             flush;
  logic             out_valid, out_ready, out_wr;
  logic [XLEN-1:0]  out_op1, out_op2, out_pc, out_imm;
  logic [4:0]       out_rd;

  int n_checks;
  int n_errors;

  operand_fetch #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_wr(in_wr), .in_pc(in_pc), .in_imm(in_imm),
    .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wr(out_wr),
    .out_pc(out_pc), .out_imm(out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x1/x2 preset, written registers override, wb bypassed
  logic [XLEN-1:0] rf_mem [32];
  logic [31:0]     rf_written = '0;

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (rf_we && rf_waddr == a) return rf_wdata;
    if (rf_written[a]) return rf_mem[a];
    if (a == 5'd1) return 32'h11;
    if (a == 5'd2) return 32'h22;
    return '0;
  endfunction

  always_comb rf_rdata1 = rf_read(rf_raddr1);
  always_comb rf_rdata2 = rf_read(rf_raddr2);

  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) begin
      rf_mem[rf_waddr]     <= rf_wdata;
      rf_written[rf_waddr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic [31:0] pc);
    in_valid   = v;
    in_rs1     = rs1;
    in_use_rs1 = u1;
    in_rs2     = rs2;
    in_use_rs2 = u2;
    in_rd      = rd;
    in_wr      = wr;
    in_pc      = pc;
    in_imm     = pc ^ 32'hFFFF_0000;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 32'h100);
    wb(1'b0, 5'd0, 32'h0);

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_op1", out_op1, 32'h0);
    check("rst_busy", dut.busy_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Back-to-back independent issue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'(10 + i), 1'b1, 32'h100 + 32'(4 * i));
      settle();
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      check("b2b_re1", 32'(rf_re1), 32'd1);
      tick();
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_op1", out_op1, 32'h11);
      check("b2b_op2", out_op2, 32'h22);
      check("b2b_pc", out_pc, 32'h100 + 32'(4 * i));
    end
    check("b2b_imm", out_imm, 32'hFFFF_0108);
    check("b2b_busy", dut.busy_q, 32'h0000_1C00);

    // RAW stall: writer rd=5 with no sources
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h200);
    settle();
    check("raw_wr_ready", 32'(in_ready), 32'd1);
    tick();
    check("raw_wr_rd", 32'(out_rd), 32'd5);
    check("raw_wr_op1_zero", out_op1, 32'h0);
    check("raw_busy5_set", 32'(dut.busy_q[5]), 32'd1);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 32'h204);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("raw_stall", 32'(in_ready), 32'd0);
      tick();
    end
    check("raw_drained", 32'(out_valid), 32'd0);
    wb(1'b1, 5'd5, 32'hDEAD);
    settle();
    check("raw_wb_ready", 32'(in_ready), 32'd1);
    check("raw_rf_we", 32'(rf_we), 32'd1);
    check("raw_rf_wdata", rf_wdata, 32'hDEAD);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    check("raw_out_valid", 32'(out_valid), 32'd1);
    check("raw_op1_bypass", out_op1, 32'hDEAD);
    check("raw_pc", out_pc, 32'h204);
    check("raw_busy5_clear", 32'(dut.busy_q[5]), 32'd0);
    check("raw_busy6_set", 32'(dut.busy_q[6]), 32'd1);

    // x0 handling
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h280);
    settle();
    check("x0_wr_ready", 32'(in_ready), 32'd1);
    tick();
    check("x0_busy0", 32'(dut.busy_q[0]), 32'd0);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h284);
    settle();
    check("x0_rd_ready", 32'(in_ready), 32'd1);
    tick();
    check("x0_rd_valid", 32'(out_valid), 32'd1);
    check("x0_rd_pc", out_pc, 32'h284);
    check("x0_busy", dut.busy_q, 32'h0000_1C40);

    // WAW plus backpressure
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    tick();
    check("waw_drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h300);
    tick();
    check("waw_first_pc", out_pc, 32'h300);
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h304);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("waw_bp_ready", 32'(in_ready), 32'd0);
      tick();
      check("waw_bp_valid", 32'(out_valid), 32'd1);
      check("waw_bp_pc", out_pc, 32'h300);
      check("waw_bp_op1", out_op1, 32'h11);
    end
    out_ready = 1'b1;
    settle();
    check("waw_hazard", 32'(in_ready), 32'd0);
    tick();
    check("waw_out_clear", 32'(out_valid), 32'd0);
    wb(1'b1, 5'd7, 32'h7777);
    settle();
    check("waw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    check("waw_second_pc", out_pc, 32'h304);
    check("waw_second_op1", out_op1, 32'h22);
    check("waw_busy7", 32'(dut.busy_q[7]), 32'd1);

    // Flush with out_valid=1 and busy[3], busy[9] set
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h400);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h404);
    tick();
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    check("fl_pre_busy", dut.busy_q & 32'h0000_0208, 32'h0000_0208);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 32'h408);
    flush = 1'b1;
    wb(1'b1, 5'd3, 32'h3333);
    settle();
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_rf_we", 32'(rf_we), 32'd1);
    check("fl_rf_waddr", 32'(rf_waddr), 32'd3);
    tick();
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_busy", dut.busy_q, 32'h0);
    check("fl_no_accept_pc", out_pc, 32'h404);

    // Reset mid-operation while stalled
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 32'h500);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 32'h504);
    tick();
    check("rm_stalled", 32'(in_ready), 32'd0);
    check("rm_pre_op1", out_op1, 32'h11);
    rst_n = 1'b0;
    #1;
    check("rm_out_valid", 32'(out_valid), 32'd0);
    check("rm_busy", dut.busy_q, 32'h0);
    check("rm_op1", out_op1, 32'h0);
    check("rm_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    settle();
    check("rm_ready_after", 32'(in_ready), 32'd1);
    tick();
    check("rm_first_accept", 32'(out_valid), 32'd1);
    check("rm_first_pc", out_pc, 32'h504);
    check("rm_first_op2", out_op2, 32'h22);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue-side initiator for the two-read/one-write register file. It takes decoded instructions, drives the register file read ports, and tracks pending destination writes in a per-register busy scoreboard. It stalls on RAW and WAW hazards, forwards retiring writebacks to the register file write port, and hands captured operands to the execute stage through a one-entry valid/ready output register.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1, in_rs2  in  5  source register indices
- in_use_rs1, in_use_rs2  in  1  source actually read
- in_rd  in  5  destination index
- in_wr  in  1  instruction writes in_rd
- in_pc, in_imm  in  XLEN  passthrough payload
- rf_re1, rf_re2  out  1  register file read enables
- rf_raddr1, rf_raddr2  out  5  register file read addresses
- rf_rdata1, rf_rdata2  in  XLEN  combinational read data; includes same-cycle write bypass
- wb_valid  in  1  writeback retiring
- wb_addr  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- rf_we  out  1  register file write enable, equals wb_valid
- rf_waddr  out  5  register file write address, equals wb_addr
- rf_wdata  out  XLEN  register file write data, equals wb_data
- flush  in  1  synchronous kill of this stage and the scoreboard
- out_valid  out  1  operands valid for execute
- out_ready  in  1  execute accepts
- out_op1, out_op2  out  XLEN  operand values; 0 when the corresponding use flag was 0
- out_rd  out  5, out_wr  out  1, out_pc  out  XLEN, out_imm  out  XLEN  registered payload

## Operation
- **Scoreboard:** busy[31:0] flops; busy[0] is hardwired to 0.
- **Effective busy:** busy_eff = busy with bit wb_addr cleared when wb_valid is asserted.
- **Hazard:** (in_use_rs1 && in_rs1!=0 && busy_eff[in_rs1]) || (in_use_rs2 && in_rs2!=0 && busy_eff[in_rs2]) || (in_wr && in_rd!=0 && busy_eff[in_rd]).
- **Ready:** in_ready = !hazard && !flush && (!out_valid || out_ready).
- **Read ports:** rf_re1 = in_valid && in_use_rs1, rf_raddr1 = in_rs1. Port 2 is identical with rs2. Reads are issued every cycle, including while stalled.
- **Accept:** capture operands and payload into the output register and set out_valid.
  - If in_wr && in_rd!=0, set busy[in_rd].
- **Writeback:** when wb_valid is asserted, clear busy[wb_addr].
  - If the same register is both set by an accept and cleared by a writeback in one cycle, the set wins.
- **Output handshake:** out_valid && out_ready with no accept clears out_valid. All out_* fields hold stable while out_valid && !out_ready.
- **Write passthrough:** rf_we/rf_waddr/rf_wdata are combinational copies of wb_*, and are forwarded even during flush.
- **Flush:**
  - Next cycle, out_valid=0 and busy=0.
  - No accept occurs in the flush cycle.
  - A writeback in the flush cycle does not alter the scoreboard beyond the clear.
  - The caller guarantees no writebacks from killed instructions arrive after flush.

## Timing
- **Reset:** out_valid=0, busy=0, all out_* data fields 0, in_ready=0 while rst_n is low.
- **Latency:** 1 cycle from accept to out_valid.
- **Throughput:** 1 instruction per cycle with no hazards and out_ready held at 1.
- **Dependent issue:** a consumer of rd can be accepted in the same cycle that wb_valid retires rd. Operand data then comes from the register file write bypass.
- **Reset mid-operation:** state clears immediately. The first accept is possible on the first rising edge after rst_n deasserts.
- **Combinational paths:** in_ready depends combinationally on in_*, wb_valid, wb_addr, flush and out_ready. There are no other combinational in-to-out paths except rf_* and rf_we*.

## Test plan
- **Back-to-back independent issue:** three instructions with no hazards, out_ready=1, register file returning x1=0x11 and x2=0x22. Required: out_valid on cycles 1, 2, 3; op1=0x11, op2=0x22; in_ready never drops.
- **RAW stall:** accept writer rd=5, then reader rs1=5. Required: in_ready=0 until wb_valid with wb_addr=5 and wb_data=0xDEAD. The reader is accepted in that same cycle with out_op1=0xDEAD, and busy[5]=0 afterwards.
- **x0 handling:** in_wr=1 with rd=0, then a reader of rs1=0. Required: no stall, and busy stays 0.
- **WAW plus backpressure:**
  - Writer rd=7, second writer rd=7, out_ready=0 for 3 cycles. Required: the second writer stalls until wb for 7.
  - The first out_* stays stable during backpressure.
  - When the second writer issues in the wb cycle, busy[7]=1 afterwards.
- **Flush:** with out_valid=1 and busy[3]=busy[9]=1, pulse flush. Required: next cycle out_valid=0 and busy=0, and no accept in the flush cycle.
- **Reset mid-operation:** assert rst_n=0 asynchronously while stalled. Required: out_valid=0, busy=0 and out_op1=0 without waiting for a clock edge.
